// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: operation codes, FSM states
// and the default operand/shift-amount widths.
package shift_pkg;

    localparam int SH_WIDTH = 32;
    localparam int SH_AMT_W = 5;

    // Codes 101..111 are reserved and act as a hold step.
    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position step of the shifter; the sequencer applies it
// once per clock to its own register.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] next_value
);

    // NOTE: the default assignment before the case keeps this process free of
    // latches, including for the reserved op codes.
    always_comb begin
        next_value = value;
        case (op)
            OP_SLL:  next_value = {value[WIDTH-2:0], 1'b0};
            OP_SRL:  next_value = {1'b0, value[WIDTH-1:1]};
            OP_SRA:  next_value = {value[WIDTH-1], value[WIDTH-1:1]};
            OP_ROR:  next_value = {value[0], value[WIDTH-1:1]};
            OP_ROL:  next_value = {value[WIDTH-2:0], value[WIDTH-1]};
            default: next_value = value;
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Iterative shifter for the multicycle datapath: captures an operand, shift
// count and op on start, applies one bit position per clock, pulses done.
module shift_reg_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH,
    parameter int SHW   = SH_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    shift_state_t     state;
    shift_state_t     state_next;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] step_value;
    logic [SHW-1:0]   count_q;
    logic [2:0]       op_q;
    logic             accept;

    // A new request is taken only when no operation is in flight.
    assign accept = start && (state == IDLE || state == DONE);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op         (op_q),
        .value      (value_q),
        .next_value (step_value)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = (shamt == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (count_q == SHW'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter is at least 1 throughout SHIFT, so the decrement never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            count_q <= '0;
            op_q    <= '0;
        end else if (accept) begin
            value_q <= data_in;
            count_q <= shamt;
            op_q    <= op;
        end else if (state == SHIFT) begin
            value_q <= step_value;
            count_q <= count_q - SHW'(1);
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        data_out = value_q;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    a_busy_done_exclusive: assert property (
        @(posedge clk) disable iff (reset) !(busy && done)
    );

    a_count_nonzero_in_shift: assert property (
        @(posedge clk) disable iff (reset) (state == SHIFT) |-> (count_q != '0)
    );

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Iterative shift register that consumes the 5-bit shift amount produced by the datapath's shift-amount select mux (rt / shamt / memory-sourced) and applies it to a 32-bit operand one bit position per clock. It sits between the shift-amount/shift-source muxes and the register-file write-back mux, and is driven by the multicycle control unit through a start/done handshake. It implements SLL, SRL, SRA, ROR and ROL. The controller holds its state while `busy` is high.

## Interface
- `WIDTH`, 32: operand width.
- `SHW`, 5: shift-amount width, equal to log2(WIDTH).

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `op` input 3: shift operation, encoded per the shared package.
- `data_in` input WIDTH: operand, captured on an accepted `start`.
- `shamt` input SHW: shift count N (0..31) from the shift-amount mux, captured on an accepted `start`.
- `busy` output 1: high while in SHIFT.
- `done` output 1: one-cycle pulse; `data_out` is valid.
- `data_out` output WIDTH: shift register contents.

## Operation
- Op encoding:
  - 000 SLL, zero fill.
  - 001 SRL, zero fill.
  - 010 SRA, replicate the MSB.
  - 011 ROR.
  - 100 ROL.
  - 101–111 reserved: the register holds its value each step, and timing is identical to a real op.
- States:
  - IDLE: `start` loads `data_in` into the register, `shamt` into the counter and `op` into the op register. Go to SHIFT if N≠0, else to DONE.
  - SHIFT: each edge applies one 1-bit step of the captured op and decrements the counter. When the counter goes 1→0, go to DONE.
  - DONE: `done`=1 for this cycle only. `start` here is accepted exactly as in IDLE, giving back-to-back operation. Otherwise go to IDLE.
- `start` during SHIFT is ignored. Changes to `data_in`, `shamt` or `op` after capture are ignored.
- `data_out` is the register itself. It holds its value in IDLE until the next accepted `start`.
- Reset values: state IDLE, `data_out`=0, counter 0, `busy`=0, `done`=0.
- `reset` in any state, including mid-SHIFT, wins over `start` and aborts the operation. No `done` is produced for the aborted operation.
- Arithmetic: the counter is SHW bits, unsigned, and never wraps (the 1→0 transition exits SHIFT). SRA shifts in the captured bit WIDTH-1 each step.

## Timing
- `start` high in cycle t (accepted) → `busy` high in cycles t+1..t+N → `done` high in cycle t+N+1 only.
- Latency is N+1 cycles. N=0 gives `done` at t+1 with `data_out`=`data_in`.
- Worst case N=31: `done` at t+32.
- `busy` and `done` are never high together.
- Back-to-back: `start` in the DONE cycle t+N+1 → new `busy`/`done` sequence from t+N+2. `data_out` is valid only in that DONE cycle before being reloaded.
- All outputs are registered or are pure functions of state. There is no combinational path from inputs to outputs.

## Structure
- Shared package `shift_pkg`:
  - `shift_op_t` with the op encodings above.
  - `shift_state_t` (IDLE, SHIFT, DONE).
  - Constants `SH_WIDTH`=32 and `SH_AMT_W`=5.
- Sub-module `shift_step`: purely combinational single-bit step (`op`, `value` → `next_value`), instantiated once and fed by the register.
- The FSM, counter and register live in `shift_reg_seq`.

## Test plan
- SLL: `data_in`=0x0000000F, N=4, `start` at t → `busy` t+1..t+4; `done` only at t+5 with `data_out`=0x000000F0.
- SRA vs SRL: 0x80000000, N=31.
  - SRA → 0xFFFFFFFF at t+32.
  - SRL → 0x00000001 at t+32.
- Rotates: 0x00000001, N=1.
  - ROR → 0x80000000 at t+2.
  - ROL, N=31, 0x00000001 → 0x80000000 at t+32.
- N=0: `data_in`=0x12345678 → no `busy`; `done` at t+1, `data_out`=0x12345678.
- Robustness: `start` asserted again with new operands during SHIFT → ignored, result unchanged. `start` in the DONE cycle → accepted, second result correct.
- Reset mid-op: `reset` at t+3 of an N=10 shift → next cycle all outputs 0, state IDLE, no `done` pulse. A following `start` works normally.
